axis_join_arbiter_rr: RTL and testbench

Parametrised N-port AXI4-Stream join arbiter. It is the next generation of the fixed 3-port join arbiter and merges S_COUNT packet streams onto one output.
- Arbitration is packet-locked and selectable between round-robin and fixed priority.
- The output has a registered skid stage and a tid sideband carrying the source port index.
- Sits in the datapath where multiple core/router streams converge before a single DMA or serialiser channel.

---
 rtl/axis_pkg.sv | 21 ++
 rtl/axis_skid_reg.sv | 52 +++++
 rtl/axis_join_arbiter_rr.sv | 129 ++++++++++++
 tb/tb_axis_join_arbiter_rr.sv | 586 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// axis_pkg: shared arbiter modes, FSM encoding and helpers
// for the AXI4-Stream join arbiter.
package axis_pkg;

   localparam int ARB_RR   = 0;
   localparam int ARB_PRIO = 1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// axis_skid_reg: two-entry register slice with fully
// registered outputs and a registered full flag.
module axis_skid_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             full,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready
);

   logic             skid_valid;
   logic [WIDTH-1:0] skid_data;
   logic             push;
   logic             pop;

   assign full = out_valid & skid_valid;
   assign push = in_valid & ~full;
   assign pop  = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else if (pop) begin
         if (skid_valid) begin
            // older skid beat moves forward first
            out_data   <= skid_data;
            skid_valid <= push;
            if (push) skid_data <= in_data;
         end else begin
            out_valid <= push;
            if (push) out_data <= in_data;
         end
      end else if (push) begin
         if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
         end else begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
         end
      end
   end

endmodule

// File: rtl/axis_join_arbiter_rr.sv
// axis_join_arbiter_rr: packet-locked N-port AXI4-Stream
// join with round-robin or fixed-priority arbitration.
module axis_join_arbiter_rr
   import axis_pkg::*;
#(
   parameter int S_COUNT     = 4,
   parameter int DATA_WIDTH  = 64,
   parameter int ARB_MODE    = ARB_RR,
   parameter int LAST_ENABLE = 1,
   parameter int ID_WIDTH    =
      (clog2(S_COUNT) < 1) ? 1 : clog2(S_COUNT)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [S_COUNT-1:0]            s_axis_tvalid,
   input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [S_COUNT-1:0]            s_axis_tlast,
   output logic [S_COUNT-1:0]            s_axis_tready,
   output logic                          m_axis_tvalid,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic                          m_axis_tlast,
   output logic [ID_WIDTH-1:0]           m_axis_tid,
   input  logic                          m_axis_tready,
   output logic                          busy
);

   localparam int SW = DATA_WIDTH + 1 + ID_WIDTH;

   state_t                state;
   state_t                state_n;
   logic [ID_WIDTH-1:0]   grant;
   logic [ID_WIDTH-1:0]   grant_n;
   logic [ID_WIDTH-1:0]   rr_ptr;
   logic [ID_WIDTH-1:0]   rr_ptr_n;
   logic [ID_WIDTH-1:0]   pick;
   logic                  skid_full;
   logic                  accept;
   logic                  release_beat;
   logic                  cur_valid;
   logic                  cur_last;
   logic [DATA_WIDTH-1:0] cur_data;
   logic [SW-1:0]         skid_out;

   function automatic logic [ID_WIDTH-1:0] arb_pick(
      input logic [S_COUNT-1:0]  req,
      input logic [ID_WIDTH-1:0] base
   );
      int   idx;
      logic found;
      arb_pick = '0;
      found    = 1'b0;
      for (int i = 0; i < S_COUNT; i++) begin
         idx = int'(base) + i;
         if (idx >= S_COUNT) idx = idx - S_COUNT;
         if (!found && req[idx]) begin
            found    = 1'b1;
            arb_pick = ID_WIDTH'(idx);
         end
      end
   endfunction

   // fixed priority is a cyclic search that always starts at 0
   assign pick = arb_pick(s_axis_tvalid,
      (ARB_MODE == ARB_PRIO) ? '0 : rr_ptr);

   assign cur_valid = s_axis_tvalid[grant];
   assign cur_last  = s_axis_tlast[grant];
   assign cur_data  =
      s_axis_tdata[int'(grant)*DATA_WIDTH +: DATA_WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         grant  <= '0;
         rr_ptr <= '0;
      end else begin
         state  <= state_n;
         grant  <= grant_n;
         rr_ptr <= rr_ptr_n;
      end
   end

   always_comb begin
      state_n  = state;
      grant_n  = grant;
      rr_ptr_n = rr_ptr;
      unique case (state)
         ST_IDLE: begin
            if (|s_axis_tvalid) begin
               state_n = ST_GRANT;
               grant_n = pick;
            end
         end
         ST_GRANT: begin
            if (release_beat) begin
               state_n  = ST_IDLE;
               rr_ptr_n = (int'(grant) == S_COUNT - 1) ?
                  '0 : grant + 1'b1;
            end
         end
      endcase
   end

   // tready sees only registered state, never m_axis_tready
   always_comb begin
      s_axis_tready = '0;
      busy          = (state == ST_GRANT);
      accept        = busy && cur_valid && !skid_full;
      release_beat  = accept &&
         (cur_last || (LAST_ENABLE == 0));
      if (busy && !skid_full) s_axis_tready[grant] = 1'b1;
   end

   axis_skid_reg #(
      .WIDTH(SW)
   ) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (accept),
      .in_data  ({cur_data, cur_last, grant}),
      .full     (skid_full),
      .out_valid(m_axis_tvalid),
      .out_data (skid_out),
      .out_ready(m_axis_tready)
   );

   assign {m_axis_tdata, m_axis_tlast, m_axis_tid} = skid_out;

endmodule

// File: tb/tb_axis_join_arbiter_rr.sv
// tb_axis_join_arbiter_rr: directed scenarios plus randomized
// traffic against a packet-level arbitration model.
`timescale 1ns/1ps
module tb_axis_join_arbiter_rr;

   localparam int N  = 4;
   localparam int DW = 64;
   localparam int IW = 2;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
      logic [IW-1:0] tid;
      int            cyc;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic [1:0]    sel;
   logic [N-1:0]  d_valid;
   logic [N-1:0]  d_last;
   logic [N*DW-1:0] d_data;
   logic          m_ready;
   logic [N-1:0]  hold;

   logic [N-1:0]  tready_o [3];
   logic          mvalid_o [3];
   logic [DW-1:0] mdata_o  [3];
   logic          mlast_o  [3];
   logic [IW-1:0] mtid_o   [3];
   logic          busy_o   [3];

   logic [N-1:0]  cur_tready;
   logic          cur_mvalid;
   logic [DW-1:0] cur_mdata;
   logic          cur_mlast;
   logic [IW-1:0] cur_mtid;
   logic          cur_busy;

   int n_cmp = 0;
   int n_err = 0;
   int cyc;
   int src_pops;
   logic [DW:0] srcq [N][$];
   logic [DW:0] mq   [N][$];
   beat_t outq[$];
   beat_t expq[$];
   bit    busy_q[$];

   // 0: round-robin, 1: fixed priority, 2: round-robin per beat
   for (genvar k = 0; k < 3; k++) begin : g_dut
      logic on;
      assign on = (sel == 2'(k));
      axis_join_arbiter_rr #(
         .S_COUNT    (N),
         .DATA_WIDTH (DW),
         .ARB_MODE   (k == 1 ? 1 : 0),
         .LAST_ENABLE(k == 2 ? 0 : 1)
      ) dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .s_axis_tvalid(on ? d_valid : '0),
         .s_axis_tdata (on ? d_data : '0),
         .s_axis_tlast (on ? d_last : '0),
         .s_axis_tready(tready_o[k]),
         .m_axis_tvalid(mvalid_o[k]),
         .m_axis_tdata (mdata_o[k]),
         .m_axis_tlast (mlast_o[k]),
         .m_axis_tid   (mtid_o[k]),
         .m_axis_tready(on ? m_ready : 1'b0),
         .busy         (busy_o[k])
      );
   end

   assign cur_tready = tready_o[sel];
   assign cur_mvalid = mvalid_o[sel];
   assign cur_mdata  = mdata_o[sel];
   assign cur_mlast  = mlast_o[sel];
   assign cur_mtid   = mtid_o[sel];
   assign cur_busy   = busy_o[sel];

   function automatic void refresh();
      logic [DW:0] b;
      for (int p = 0; p < N; p++) begin
         b = '0;
         if (srcq[p].size() > 0) b = srcq[p][0];
         d_valid[p] = srcq[p].size() > 0 && !hold[p];
         d_data[p*DW +: DW] = b[DW-1:0];
         d_last[p] = b[DW];
      end
   endfunction

   task automatic step();
      logic [N-1:0] f;
      logic [DW:0]  tmp;
      beat_t        b;
      @(negedge clk);
      f = d_valid & cur_tready;
      busy_q.push_back(cur_busy);
      if (cur_mvalid && m_ready) begin
         b.data = cur_mdata;
         b.last = cur_mlast;
         b.tid  = cur_mtid;
         b.cyc  = cyc;
         outq.push_back(b);
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int p = 0; p < N; p++)
         if (f[p] && srcq[p].size() > 0) begin
            tmp = srcq[p].pop_front();
            src_pops++;
         end
      refresh();
   endtask

   task automatic clear_all();
      m_ready = 1'b1;
      hold    = '0;
      for (int p = 0; p < N; p++) srcq[p].delete();
      refresh();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_all();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      cyc = 0;
      src_pops = 0;
      outq.delete();
      busy_q.delete();
   endtask

   task automatic run_beats(input int n, input int budget,
                            output bit ok);
      int c;
      c = 0;
      while (outq.size() < n && c < budget) begin
         step();
         c++;
      end
      ok = outq.size() >= n;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_all();
      srcq[0].push_back({1'b1, 64'hdead});
      refresh();
      repeat (3) @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         sel = 2'(k);
         #1;
         n_cmp++;
         if ({cur_tready, cur_mvalid, cur_mlast, cur_mtid,
              cur_busy, cur_mdata} !== '0) begin
            n_err++;
            $display("FAIL reset_state[%0d]: got tready=%b v=%b l=%b id=%0d busy=%b d=%h, want all 0",
               k, cur_tready, cur_mvalid, cur_mlast, cur_mtid,
               cur_busy, cur_mdata);
         end
      end
      sel = 2'd0;
      do_reset();
   endtask

   task automatic test_rr_burst();
      beat_t exp[$];
      beat_t e;
      logic [DW-1:0] dv;
      bit ok;
      sel = 2'd0;
      do_reset();
      for (int p = 0; p < N; p++)
         for (int k = 0; k < 3; k++) begin
            dv = {$urandom, $urandom};
            srcq[p].push_back({k == 2, dv});
            e.data = dv;
            e.last = (k == 2);
            e.tid  = IW'(p);
            e.cyc  = 2 + 4 * p + k;
            exp.push_back(e);
         end
      refresh();
      run_beats(12, 100, ok);
      repeat (3) step();
      n_cmp++;
      if (outq.size() != 12) begin
         n_err++;
         $display("FAIL burst_count: got %0d beats, want 12",
            outq.size());
      end
      for (int i = 0; i < 12 && i < outq.size(); i++) begin
         n_cmp++;
         if (outq[i] !== exp[i]) begin
            n_err++;
            $display("FAIL burst_beat[%0d]: got id=%0d d=%h l=%b cyc=%0d, want id=%0d d=%h l=%b cyc=%0d",
               i, outq[i].tid, outq[i].data, outq[i].last,
               outq[i].cyc, exp[i].tid, exp[i].data,
               exp[i].last, exp[i].cyc);
         end
      end
      n_cmp++;
      if ({busy_q[1], busy_q[4], busy_q[16]} !== 3'b100) begin
         n_err++;
         $display("FAIL burst_busy: got c1/c4/c16=%b%b%b, want 100",
            busy_q[1], busy_q[4], busy_q[16]);
      end
   endtask

   task automatic test_fairness();
      beat_t exp[$];
      beat_t e;
      logic [DW-1:0] dv;
      bit ok;
      for (int m = 0; m < 2; m++) begin
         sel = 2'(m);
         do_reset();
         exp.delete();
         for (int k = 0; k < 20; k++)
            for (int p = 1; p <= 2; p++) begin
               dv = {$urandom, $urandom};
               srcq[p].push_back({1'b1, dv});
               e.data = dv;
               e.last = 1'b1;
               e.tid  = IW'(p);
               e.cyc  = 0;
               if (m == 0 && k < 10) exp.push_back(e);
               if (m == 1 && p == 1) exp.push_back(e);
            end
         refresh();
         run_beats(20, 200, ok);
         n_cmp++;
         if (!ok) begin
            n_err++;
            $display("FAIL fair_timeout[%0d]: got %0d beats, want 20",
               m, outq.size());
         end
         for (int i = 0; i < 20 && i < outq.size(); i++) begin
            n_cmp++;
            if ({outq[i].data, outq[i].last, outq[i].tid} !==
                {exp[i].data, exp[i].last, exp[i].tid}) begin
               n_err++;
               $display("FAIL fair_beat[%0d][%0d]: got id=%0d d=%h, want id=%0d d=%h",
                  m, i, outq[i].tid, outq[i].data,
                  exp[i].tid, exp[i].data);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int c;
      sel = 2'd0;
      do_reset();
      for (int k = 0; k < 6; k++)
         srcq[3].push_back({k == 5, 64'(16 + k)});
      refresh();
      c = 0;
      while (outq.size() < 1 && c < 20) begin
         step();
         c++;
      end
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if ({cur_mvalid, cur_mdata, cur_mlast, cur_mtid} !==
             {1'b1, 64'h11, 1'b0, 2'd3}) begin
            n_err++;
            $display("FAIL bp_stable[%0d]: got v=%b d=%h l=%b id=%0d, want v=1 d=11 l=0 id=3",
               i, cur_mvalid, cur_mdata, cur_mlast, cur_mtid);
         end
         n_cmp++;
         if (src_pops - outq.size() > 2) begin
            n_err++;
            $display("FAIL bp_buffered[%0d]: got %0d, want <=2",
               i, src_pops - outq.size());
         end
         if (i >= 1) begin
            n_cmp++;
            if (cur_tready[3] !== 1'b0) begin
               n_err++;
               $display("FAIL bp_tready[%0d]: got %b, want 0",
                  i, cur_tready[3]);
            end
         end
         step();
      end
      m_ready = 1'b1;
      run_beats(6, 50, ok);
      repeat (4) step();
      n_cmp++;
      if (outq.size() != 6) begin
         n_err++;
         $display("FAIL bp_count: got %0d, want 6", outq.size());
      end
      for (int i = 0; i < 6 && i < outq.size(); i++) begin
         n_cmp++;
         if ({outq[i].data, outq[i].last, outq[i].tid} !==
             {64'(16 + i), i == 5, 2'd3}) begin
            n_err++;
            $display("FAIL bp_beat[%0d]: got d=%h l=%b id=%0d, want d=%h l=%b id=3",
               i, outq[i].data, outq[i].last, outq[i].tid,
               64'(16 + i), i == 5);
         end
      end
   endtask

   task automatic test_packet_lock();
      logic [DW-1:0] ed [6];
      logic [IW-1:0] et [6];
      bit ok;
      sel = 2'd0;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         srcq[0].push_back({k == 3, 64'(32 + k)});
         ed[k] = 64'(32 + k);
         et[k] = 2'd0;
      end
      refresh();
      step();
      step();
      for (int k = 0; k < 2; k++) begin
         srcq[2].push_back({k == 1, 64'(48 + k)});
         ed[4 + k] = 64'(48 + k);
         et[4 + k] = 2'd2;
      end
      hold[0] = 1'b1;
      refresh();
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if ({cur_busy, cur_tready} !== 5'b1_0001) begin
            n_err++;
            $display("FAIL lock_bubble[%0d]: got busy=%b tready=%b, want 1 0001",
               i, cur_busy, cur_tready);
         end
         step();
      end
      hold[0] = 1'b0;
      refresh();
      run_beats(6, 60, ok);
      n_cmp++;
      if (!ok) begin
         n_err++;
         $display("FAIL lock_timeout: got %0d beats, want 6",
            outq.size());
      end
      for (int i = 0; i < 6 && i < outq.size(); i++) begin
         n_cmp++;
         if ({outq[i].data, outq[i].tid} !== {ed[i], et[i]}) begin
            n_err++;
            $display("FAIL lock_beat[%0d]: got id=%0d d=%h, want id=%0d d=%h",
               i, outq[i].tid, outq[i].data, et[i], ed[i]);
         end
      end
      if (outq.size() >= 5) begin
         n_cmp++;
         if (outq[4].cyc < outq[3].cyc + 2) begin
            n_err++;
            $display("FAIL lock_gap: got cyc %0d after %0d, want >= +2",
               outq[4].cyc, outq[3].cyc);
         end
      end
   endtask

   task automatic test_no_last();
      logic [DW-1:0] a [2];
      logic [DW-1:0] b [2];
      logic [DW-1:0] ed [4];
      bit ok;
      sel = 2'd2;
      do_reset();
      for (int k = 0; k < 2; k++) begin
         a[k] = {$urandom, $urandom};
         b[k] = {$urandom, $urandom};
         srcq[0].push_back({k == 1, a[k]});
         srcq[1].push_back({k == 1, b[k]});
      end
      ed[0] = a[0];
      ed[1] = b[0];
      ed[2] = a[1];
      ed[3] = b[1];
      refresh();
      run_beats(4, 60, ok);
      n_cmp++;
      if (!ok) begin
         n_err++;
         $display("FAIL nolast_timeout: got %0d, want 4",
            outq.size());
      end
      for (int i = 0; i < 4 && i < outq.size(); i++) begin
         n_cmp++;
         if ({outq[i].data, outq[i].last, outq[i].tid} !==
             {ed[i], i >= 2, IW'(i % 2)}) begin
            n_err++;
            $display("FAIL nolast_beat[%0d]: got id=%0d l=%b d=%h, want id=%0d l=%b d=%h",
               i, outq[i].tid, outq[i].last, outq[i].data,
               i % 2, i >= 2, ed[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int c;
      sel = 2'd0;
      do_reset();
      srcq[2].push_back({1'b1, 64'h22});
      refresh();
      run_beats(1, 20, ok);
      repeat (2) step();
      for (int k = 0; k < 4; k++)
         srcq[1].push_back({k == 3, 64'(64 + k)});
      refresh();
      c = 0;
      while (outq.size() < 2 && c < 20) begin
         step();
         c++;
      end
      n_cmp++;
      if ({cur_mvalid, cur_busy} !== 2'b11) begin
         n_err++;
         $display("FAIL rmid_pre: got v=%b busy=%b, want 1 1",
            cur_mvalid, cur_busy);
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({cur_tready, cur_mvalid, cur_mlast, cur_mtid,
           cur_busy, cur_mdata} !== '0) begin
         n_err++;
         $display("FAIL rmid_async: got tready=%b v=%b l=%b id=%0d busy=%b d=%h, want all 0",
            cur_tready, cur_mvalid, cur_mlast, cur_mtid,
            cur_busy, cur_mdata);
      end
      clear_all();
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc = 0;
      src_pops = 0;
      outq.delete();
      busy_q.delete();
      srcq[0].push_back({1'b1, 64'h50});
      srcq[3].push_back({1'b1, 64'h53});
      refresh();
      step();
      n_cmp++;
      if ({cur_busy, cur_tready} !== 5'b1_0001) begin
         n_err++;
         $display("FAIL rmid_grant: got busy=%b tready=%b, want 1 0001",
            cur_busy, cur_tready);
      end
      run_beats(2, 20, ok);
      repeat (3) step();
      n_cmp++;
      if (outq.size() != 2) begin
         n_err++;
         $display("FAIL rmid_count: got %0d, want 2", outq.size());
      end else begin
         n_cmp++;
         if ({outq[0].tid, outq[0].data[7:0],
              outq[1].tid, outq[1].data[7:0]} !==
             {2'd0, 8'h50, 2'd3, 8'h53}) begin
            n_err++;
            $display("FAIL rmid_order: got %0d/%h %0d/%h, want 0/50 3/53",
               outq[0].tid, outq[0].data, outq[1].tid,
               outq[1].data);
         end
      end
   endtask

   // packet-level model: every port with queued beats requests,
   // each grant drains one packet (or one beat without tlast)
   function automatic void build_expected(input bit prio,
                                          input bit per_beat);
      int ptr;
      int p;
      int q;
      logic [DW:0] b;
      beat_t e;
      ptr = 0;
      expq.delete();
      do begin
         p = -1;
         for (int i = 0; i < N; i++) begin
            q = prio ? i : (ptr + i) % N;
            if (p < 0 && mq[q].size() > 0) p = q;
         end
         if (p >= 0) begin
            do begin
               b = mq[p].pop_front();
               e.data = b[DW-1:0];
               e.last = b[DW];
               e.tid  = IW'(p);
               e.cyc  = 0;
               expq.push_back(e);
            end while (!per_beat && !b[DW] && mq[p].size() > 0);
            ptr = (p + 1) % N;
         end
      end while (p >= 0);
   endfunction

   task automatic test_random();
      logic [DW:0] b;
      int npk;
      int len;
      int c;
      for (int m = 0; m < 3; m++)
         for (int it = 0; it < 3; it++) begin
            sel = 2'(m);
            do_reset();
            for (int p = 0; p < N; p++) begin
               mq[p].delete();
               npk = $urandom_range(0, 3);
               for (int k = 0; k < npk; k++) begin
                  len = $urandom_range(1, 4);
                  for (int j = 0; j < len; j++) begin
                     b = {j == len - 1, $urandom, $urandom};
                     srcq[p].push_back(b);
                     mq[p].push_back(b);
                  end
               end
            end
            build_expected(m == 1, m == 2);
            refresh();
            c = 0;
            while (outq.size() < expq.size() && c < 2000) begin
               m_ready = ($urandom_range(0, 3) != 0);
               step();
               c++;
            end
            m_ready = 1'b1;
            repeat (4) step();
            n_cmp++;
            if (outq.size() != expq.size()) begin
               n_err++;
               $display("FAIL rand_count[%0d.%0d]: got %0d, want %0d",
                  m, it, outq.size(), expq.size());
            end
            for (int i = 0; i < expq.size() && i < outq.size();
                 i++) begin
               n_cmp++;
               if ({outq[i].data, outq[i].last, outq[i].tid} !==
                   {expq[i].data, expq[i].last, expq[i].tid})
               begin
                  n_err++;
                  $display("FAIL rand_beat[%0d.%0d.%0d]: got id=%0d l=%b d=%h, want id=%0d l=%b d=%h",
                     m, it, i, outq[i].tid, outq[i].last,
                     outq[i].data, expq[i].tid, expq[i].last,
                     expq[i].data);
               end
            end
         end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      sel = 2'd0;
      rst_n = 1'b0;
      cyc = 0;
      src_pops = 0;
      clear_all();
      test_reset();
      test_rr_burst();
      test_fairness();
      test_backpressure();
      test_packet_lock();
      test_no_last();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
         n_cmp, n_err);
      $finish;
   end

endmodule
